// File: rtl/sys_pio_pkg.sv
// Shared definitions for the pulse-capable PIO output block: register map,
// STATUS bit layout and the pulse FSM state type.
package sys_pio_pkg;

    localparam int unsigned ADDR_W       = 3;
    localparam int unsigned BUS_W        = 32;

    // Avalon-MM word offsets
    localparam logic [ADDR_W-1:0] ADDR_DATA       = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_PULSE_LEN  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PULSE_MASK = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS     = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET     = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR   = 3'd5;

    // STATUS layout: busy, sticky overrun, remaining count in the upper bits
    localparam int unsigned STATUS_BUSY_BIT    = 0;
    localparam int unsigned STATUS_OVERRUN_BIT = 1;
    localparam int unsigned STATUS_CNT_LSB     = 8;

    typedef enum logic {
        PULSE_IDLE   = 1'b0,
        PULSE_ACTIVE = 1'b1
    } pulse_state_e;

endpackage

// File: rtl/sys_pio_pulse_timer.sv
// One-shot pulse timer: holds the active XOR mask for PULSE_LEN cycles and
// flags PULSE_MASK writes that arrive while a pulse is still running.
module sys_pio_pulse_timer
    import sys_pio_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mask_wr,
    input  logic [WIDTH-1:0] mask_in,
    input  logic [CNT_W-1:0] pulse_len,
    input  logic             overrun_clr,
    output logic [WIDTH-1:0] active_mask,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] cnt
);

    pulse_state_e     state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] mask_q,    mask_d;
    logic             overrun_q, overrun_d;

    // Next-state: start on a valid mask write, count down, drop the mask on the last cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        overrun_d = overrun_q;

        case (state_q)
            PULSE_IDLE: begin
                if (mask_wr && (mask_in != '0) && (pulse_len != '0)) begin
                    state_d = PULSE_ACTIVE;
                    mask_d  = mask_in;
                    cnt_d   = pulse_len;
                end
            end
            PULSE_ACTIVE: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = PULSE_IDLE;
                    mask_d  = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = PULSE_IDLE;
                mask_d  = '0;
                cnt_d   = '0;
            end
        endcase

        // A set in the same cycle as a clear wins
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (mask_wr && (state_q == PULSE_ACTIVE)) begin
            overrun_d = 1'b1;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= PULSE_IDLE;
            cnt_q     <= '0;
            mask_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            overrun_q <= overrun_d;
        end
    end

    assign active_mask = mask_q;
    assign busy        = (state_q == PULSE_ACTIVE);
    assign overrun     = overrun_q;
    assign cnt         = cnt_q;

endmodule

// File: rtl/sys_pio_out_pulse.sv
// Avalon-MM PIO output port with set/clear strobes. Optional one-shot pulse
// overlay (XOR mask held for PULSE_LEN cycles) is compiled in when the macro
// SYS_PIO_OUT_PULSE_EN is defined; otherwise offsets 1-3 are inert.
module sys_pio_out_pulse
    import sys_pio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      CNT_W       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [BUS_W-1:0]  writedata,
    output logic [BUS_W-1:0]  readdata,
    output logic [WIDTH-1:0]  out_port
);

    logic             wr_en;
    logic [WIDTH-1:0] wr_val;
    logic [WIDTH-1:0] data_q, data_d;

    assign wr_en  = chipselect && !write_n;
    assign wr_val = writedata[WIDTH-1:0];

    // DATA update: direct write, bitwise set, bitwise clear
    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_d = wr_val;
                ADDR_OUTSET:   data_d = data_q | wr_val;
                ADDR_OUTCLEAR: data_d = data_q & ~wr_val;
                default:       data_d = data_q;
            endcase
        end
    end

    // DATA register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

`ifdef SYS_PIO_OUT_PULSE_EN
    logic [CNT_W-1:0] pulse_len_q, pulse_len_d;
    logic [WIDTH-1:0] active_mask;
    logic             busy;
    logic             overrun;
    logic [CNT_W-1:0] cnt;
    logic             mask_wr;
    logic             overrun_clr;

    assign mask_wr     = wr_en && (address == ADDR_PULSE_MASK);
    assign overrun_clr = wr_en && (address == ADDR_STATUS) && writedata[STATUS_OVERRUN_BIT];

    // PULSE_LEN is only sampled when a pulse starts, so mid-pulse writes land on the next one
    always_comb begin
        pulse_len_d = pulse_len_q;
        if (wr_en && (address == ADDR_PULSE_LEN)) begin
            pulse_len_d = writedata[CNT_W-1:0];
        end
    end

    // PULSE_LEN register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pulse_len_q <= '0;
        end else begin
            pulse_len_q <= pulse_len_d;
        end
    end

    sys_pio_pulse_timer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .mask_wr     (mask_wr),
        .mask_in     (wr_val),
        .pulse_len   (pulse_len_q),
        .overrun_clr (overrun_clr),
        .active_mask (active_mask),
        .busy        (busy),
        .overrun     (overrun),
        .cnt         (cnt)
    );

    // Pins are an XOR of two flops; writedata never reaches them combinationally
    assign out_port = data_q ^ active_mask;

    // Zero-wait-state read mux
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:       readdata = BUS_W'(data_q);
            ADDR_PULSE_LEN:  readdata = BUS_W'(pulse_len_q);
            ADDR_PULSE_MASK: readdata = BUS_W'(active_mask);
            ADDR_STATUS: begin
                readdata = BUS_W'(cnt) << STATUS_CNT_LSB;
                readdata[STATUS_BUSY_BIT]    = busy;
                readdata[STATUS_OVERRUN_BIT] = overrun;
            end
            default:         readdata = '0;
        endcase
    end
`else
    assign out_port = data_q;

    // Zero-wait-state read mux; only DATA is readable
    always_comb begin
        readdata = '0;
        if (address == ADDR_DATA) begin
            readdata = BUS_W'(data_q);
        end
    end
`endif

endmodule

// File: tb/tb_sys_pio_out_pulse.sv
// Directed + randomized bench for sys_pio_out_pulse. The reference model keeps
// the pulse as an end timestamp rather than a state machine.
module tb_sys_pio_out_pulse;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 16;
    localparam logic [31:0] RV    = 32'hC3C3_0001;
`ifdef SYS_PIO_OUT_PULSE_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_port;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_data;
    logic [15:0] m_len;
    logic [31:0] m_mask;
    int          m_end;
    logic        m_ovr;
    int          cyc;
    bit          m_valid = 1'b0;

    always #5 clk = ~clk;

    sys_pio_out_pulse #(
        .WIDTH       (WIDTH),
        .CNT_W       (CNT_W),
        .RESET_VALUE (RV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    function automatic bit m_busy();
        return cyc < m_end;
    endfunction

    function automatic logic [31:0] m_out();
        return m_data ^ (m_busy() ? m_mask : 32'h0);
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] s;
        s = 32'h0;
        case (a)
            3'd0: s = m_data;
            3'd1: if (EN) s = {16'h0, m_len};
            3'd2: if (EN && m_busy()) s = m_mask;
            3'd3: if (EN) begin
                if (m_busy()) s = 32'(m_end - cyc) << 8;
                s[1] = m_ovr;
                s[0] = m_busy();
            end
            default: s = 32'h0;
        endcase
        return s;
    endfunction

    task automatic model_apply(input logic rst, input logic cs, input logic wn,
                               input logic [2:0] a, input logic [31:0] wd);
        bit busy_now;
        busy_now = m_busy();
        if (!rst) begin
            m_data  = RV;
            m_len   = 16'h0;
            m_mask  = 32'h0;
            m_end   = 0;
            m_ovr   = 1'b0;
            m_valid = 1'b1;
        end else if (cs && !wn) begin
            case (a)
                3'd0: m_data = wd;
                3'd1: if (EN) m_len = wd[15:0];
                3'd2: if (EN) begin
                    if (busy_now) m_ovr = 1'b1;
                    else if (wd != 32'h0 && m_len != 16'h0) begin
                        m_mask = wd;
                        m_end  = cyc + 1 + int'(m_len);
                    end
                end
                3'd3: if (EN && wd[1]) m_ovr = 1'b0;
                3'd4: m_data = m_data | wd;
                3'd5: m_data = m_data & ~wd;
                default: ;
            endcase
        end
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, check read mux before the edge, check pins after it
    task automatic step(input logic rst, input logic cs, input logic wn,
                        input logic [2:0] a, input logic [31:0] wd);
        reset_n = rst; chipselect = cs; write_n = wn; address = a; writedata = wd;
        #1;
        if (m_valid) chk($sformatf("readdata@%0d", a), readdata, m_read(a));
        @(posedge clk);
        model_apply(rst, cs, wn, a, wd);
        @(negedge clk);
        if (m_valid) chk("out_port", out_port, m_out());
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b1, 1'b1, 1'b1, a, 32'h0);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
    endtask

    task automatic peek(input string tag, input logic [2:0] a, input logic [31:0] exp);
        reset_n = 1'b1; chipselect = 1'b1; write_n = 1'b1; address = a; writedata = 32'h0;
        #1;
        chk(tag, readdata, exp);
    endtask

    initial begin
        logic [2:0]  ra;
        logic        rcs, rwn, rrst;
        logic [31:0] rwd;

        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'h0;
        m_data = 32'h0; m_len = 16'h0; m_mask = 32'h0; m_end = 0; m_ovr = 1'b0; cyc = 0;
        @(negedge clk);

        // Reset state
        step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
        chk("reset_out", out_port, RV);
        peek("reset_data", 3'd0, RV);
        peek("reset_status", 3'd3, 32'h0);

        // DATA / OUTSET / OUTCLEAR
        wr(3'd0, 32'hA5A5_0F0F); chk("data_wr", out_port, 32'hA5A5_0F0F);
        wr(3'd4, 32'h0000_00F0); chk("outset",  out_port, 32'hA5A5_0FFF);
        wr(3'd5, 32'h0000_000F); chk("outclr",  out_port, 32'hA5A5_0FF0);
        step(1'b1, 1'b0, 1'b0, 3'd0, 32'hDEAD_BEEF);
        chk("cs_low_ignored", out_port, 32'hA5A5_0FF0);

        // Reserved offsets
        wr(3'd6, 32'hFFFF_FFFF);
        wr(3'd7, 32'h1234_5678);
        peek("rsvd6", 3'd6, 32'h0);
        peek("rsvd7", 3'd7, 32'h0);
        peek("wo_outset", 3'd4, 32'h0);

`ifdef SYS_PIO_OUT_PULSE_EN
        // Basic 3-cycle pulse
        wr(3'd1, 32'd3); wr(3'd0, 32'h0); wr(3'd2, 32'h1);
        chk("p3_c1", out_port, 32'h1);
        peek("p3_busy", 3'd3, 32'h0000_0301);
        rd(3'd3); rd(3'd3); chk("p3_c3", out_port, 32'h1);
        rd(3'd3); chk("p3_end", out_port, 32'h0);

        // Overrun
        wr(3'd1, 32'd5); wr(3'd2, 32'h2);
        idle();
        wr(3'd2, 32'h4);
        chk("ovr_ignored", out_port, 32'h2);
        for (int i = 0; i < 6; i++) idle();
        peek("ovr_set", 3'd3, 32'h2);
        wr(3'd3, 32'h2);
        peek("ovr_clr", 3'd3, 32'h0);

        // OUTCLEAR mid-pulse
        wr(3'd0, 32'hFF); wr(3'd1, 32'd4); wr(3'd2, 32'h0F);
        chk("mix_start", out_port, 32'hF0);
        idle();
        wr(3'd5, 32'hF0); chk("mix_mid", out_port, 32'h00);
        idle(); idle(); chk("mix_after", out_port, 32'h0F);

        // Reset mid-pulse at count 6
        wr(3'd1, 32'd10); wr(3'd2, 32'h3C);
        for (int i = 0; i < 20 && (m_end - cyc) != 6; i++) idle();
        chk("cnt6_reached", 32'(m_end - cyc), 32'd6);
        peek("cnt6_status", 3'd3, 32'h0000_0601);
        step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
        chk("rst_mid_out", out_port, RV);
        peek("rst_mid_status", 3'd3, 32'h0);

        // Ignored pulse requests
        wr(3'd1, 32'd0); wr(3'd2, 32'h1);
        chk("len0_nopulse", out_port, RV);
        peek("len0_status", 3'd3, 32'h0);
        wr(3'd1, 32'd2); wr(3'd2, 32'h0);
        chk("mask0_nopulse", out_port, RV);
        peek("mask0_status", 3'd3, 32'h0);
        peek("len_rb", 3'd1, 32'd2);
`else
        // Pulse registers absent
        wr(3'd1, 32'd5); wr(3'd2, 32'h1); wr(3'd3, 32'h2);
        peek("nopulse_len", 3'd1, 32'h0);
        peek("nopulse_mask", 3'd2, 32'h0);
        peek("nopulse_status", 3'd3, 32'h0);
        chk("nopulse_out", out_port, 32'hA5A5_0FF0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            ra   = 3'($urandom_range(0, 7));
            rcs  = ($urandom_range(0, 9) != 0);
            rwn  = ($urandom_range(0, 2) == 0);
            rrst = ($urandom_range(0, 80) != 0);
            case (ra)
                3'd1:    rwd = 32'($urandom_range(0, 6));
                3'd2:    rwd = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
                default: rwd = 32'($urandom);
            endcase
            step(rrst, rcs, rwn, ra, rwd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sys_pio_out_pulse.md
SYS_PIO_OUT_PULSE -- requirements
Module: sys_pio_out_pulse

Interface
REQ-001 SHALL have parameter WIDTH, default 32, output port width (1..32).
REQ-002 SHALL have parameter CNT_W, default 16, pulse counter width (1..32).
REQ-003 SHALL have parameter RESET_VALUE, default 0, reset value of DATA.
REQ-004 clk  input  1  single clock, all logic rising-edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe, valid with chipselect.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  read data, zero wait states, combinational from address.
REQ-011 out_port  output  WIDTH  driven output pins.

Function
REQ-012 Write = chipselect && !write_n, acting on the rising edge of that cycle.
REQ-013 Map: 0 DATA r/w; 1 PULSE_LEN r/w (CNT_W bits); 2 PULSE_MASK w, reads the active mask; 3 STATUS r/w1c; 4 OUTSET w; 5 OUTCLEAR w; 6-7 reserved.
REQ-014 Write DATA: DATA <= writedata[WIDTH-1:0].
REQ-015 Write OUTSET: DATA <= DATA | writedata; OUTCLEAR: DATA <= DATA & ~writedata; zero bits leave DATA unchanged.
REQ-016 out_port SHALL equal DATA XOR ACTIVE_MASK, registered-source only, with no combinational path from writedata.
REQ-017 Pulse FSM states: IDLE, ACTIVE.
REQ-018 IDLE to ACTIVE on a PULSE_MASK write with a nonzero mask and PULSE_LEN != 0: ACTIVE_MASK <= mask, CNT <= PULSE_LEN.
REQ-019 In ACTIVE, CNT decrements each cycle; when CNT==1, next state is IDLE and ACTIVE_MASK <= 0; each pulse is exactly PULSE_LEN cycles, starting the cycle after the write.
REQ-020 A PULSE_MASK write with mask==0 or PULSE_LEN==0 SHALL be ignored, with no state change.
REQ-021 A PULSE_MASK write in ACTIVE SHALL be ignored and set STATUS.OVERRUN (sticky).
REQ-022 STATUS read: bit0 BUSY (ACTIVE), bit1 OVERRUN, bits[31:8] CNT zero-extended.
REQ-023 Writing STATUS with bit1=1 clears OVERRUN; if a set (REQ-021) and a clear occur in the same cycle, set wins.
REQ-024 DATA/OUTSET/OUTCLEAR writes during ACTIVE update DATA normally; the pulse continues unaffected.
REQ-025 A PULSE_LEN write during ACTIVE takes effect only on the next pulse.
REQ-026 Reserved or unwritten addresses read 0; writes to them have no effect.
REQ-027 Unused upper bits of readdata read 0.

Reset
REQ-028 With reset_n low at a clock edge: DATA=RESET_VALUE, PULSE_LEN=0, ACTIVE_MASK=0, CNT=0, OVERRUN=0, state IDLE.
REQ-029 Reset mid-pulse SHALL abort the pulse; out_port=RESET_VALUE in the cycle after the reset edge.

Configuration
REQ-030 Macro SYS_PIO_OUT_PULSE_EN: when defined, the pulse function (REQ-017..025) is compiled in.
REQ-031 Without SYS_PIO_OUT_PULSE_EN: addresses 1-3 read 0 and ignore writes; out_port=DATA; there is no counter logic; DATA/OUTSET/OUTCLEAR are unchanged.

Structure
REQ-032 Package sys_pio_pkg SHALL hold the register offset constants, STATUS bit positions and the pulse state enum.
REQ-033 Sub-module sys_pio_pulse_timer (FSM, CNT, ACTIVE_MASK, OVERRUN) SHALL be instantiated only under SYS_PIO_OUT_PULSE_EN.

Verification
REQ-034 Reset, write DATA=0xA5A5_0F0F, then OUTSET 0x0000_00F0, then OUTCLEAR 0x0000_000F -> out_port 0xA5A5_0F0F, 0xA5A5_0FFF, 0xA5A5_0FF0.
REQ-035 PULSE_LEN=3, DATA=0, PULSE_MASK=0x1 at cycle N -> out_port=0x1 for cycles N+1..N+3 and 0 at N+4; BUSY=1 during the pulse.
REQ-036 PULSE_LEN=5, pulse 0x2; a second PULSE_MASK 0x4 at cycle 2 of the pulse -> ignored; OVERRUN=1; STATUS write 0x2 -> OVERRUN=0.
REQ-037 DATA=0xFF, pulse mask 0x0F with LEN=4, OUTCLEAR 0xF0 mid-pulse -> out_port 0xF0, then 0x00 mid-pulse, then 0x0F after the pulse.
REQ-038 PULSE_LEN=10, pulse active, reset_n low for one cycle at count 6 -> out_port=RESET_VALUE, BUSY=0, CNT=0.
REQ-039 PULSE_LEN=0 or mask 0 writes, plus reads of addresses 6/7 -> no pulse and readdata=0; build without the macro -> addresses 1-3 read 0.
